// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: single-clock IF/ID/EX/WB pipeline control with
// RAW scoreboard, multi-cycle long ops and a timed memory handshake.
module pipe_ctrl_unit #(
  parameter int REGW     = 4,
  parameter int OPW      = 4,
  parameter int LONG_CYC = 2,
  parameter int MEM_TO   = 15
) (
  input  logic            clk_in,
  input  logic            rst_n,
  input  logic            start_pr,
  output logic            end_pr,
  output logic            if_en,
  output logic            pc_load,
  input  logic [OPW-1:0]  id_op,
  input  logic [REGW-1:0] id_rd,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_rd_we,
  input  logic            id_rs1_use,
  input  logic            id_rs2_use,
  input  logic            id_is_long,
  input  logic            id_is_mem,
  input  logic            id_is_branch,
  input  logic            id_is_stop,
  output logic            id_adv,
  output logic            ex_valid,
  output logic [OPW-1:0]  ex_op,
  input  logic            ex_branch_taken,
  output logic            mem_req,
  input  logic            mem_ack,
  output logic            wb_en,
  output logic [REGW-1:0] wb_sel,
  output logic            mem_err
);
  localparam int NREG = 2**REGW;
  localparam logic [3:0] LC = 4'(LONG_CYC);
  localparam logic [7:0] MT = 8'(MEM_TO);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t          r_state;
  logic            r_v_id, r_v_ex, r_v_wb;
  logic [NREG-1:0] r_sb;
  logic [OPW-1:0]  r_ex_op;
  logic [REGW-1:0] r_ex_rd, r_wb_rd;
  logic            r_ex_we, r_ex_long, r_ex_mem;
  logic            r_ex_br, r_ex_stop;
  logic            r_wb_we, r_wb_clr, r_wb_stop;
  logic [3:0]      r_cnt;
  logic [7:0]      r_mcnt;
  logic            r_mem_err;

  logic            w_to, w_ex_done, w_flush, w_kill;
  logic            w_haz, w_adv, w_run;
  logic [NREG-1:0] w_set, w_clr;

  assign w_to = r_v_ex & r_ex_mem & (r_mcnt == MT);

  always_comb begin
    w_ex_done = 1'b0;
    if (!r_v_ex)        w_ex_done = 1'b0;
    else if (r_ex_mem)  w_ex_done = mem_ack | w_to;
    else if (r_ex_long) w_ex_done = (r_cnt == LC);
    else                w_ex_done = 1'b1;
  end

  assign w_flush = w_ex_done & r_ex_br & ex_branch_taken;
  // timeout also squashes ID so nothing new enters after the error
  assign w_kill = w_flush | w_to;
  assign w_haz = r_v_id &
    ((id_rs1_use & r_sb[id_rs1]) |
     (id_rs2_use & r_sb[id_rs2]));
  assign w_adv = r_v_id & ~w_haz & ~w_kill &
    (~r_v_ex | w_ex_done);
  assign w_run = (r_state == S_RUN);

  assign w_set = (w_adv & id_rd_we) ?
    (NREG'(1) << id_rd) : '0;
  assign w_clr = (r_v_wb & r_wb_clr) ?
    (NREG'(1) << r_wb_rd) : '0;

  assign if_en = w_run & ~w_kill &
    (~r_v_id | (w_adv & ~id_is_stop));
  assign pc_load  = w_flush;
  assign id_adv   = w_adv;
  assign ex_valid = r_v_ex;
  assign ex_op    = r_ex_op;
  assign mem_req  = r_v_ex & r_ex_mem & ~w_to;
  assign wb_en    = r_v_wb & r_wb_we;
  assign wb_sel   = r_wb_rd;
  assign mem_err  = r_mem_err;
  assign end_pr   = (r_state == S_DONE);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_v_id    <= 1'b0;
      r_v_ex    <= 1'b0;
      r_v_wb    <= 1'b0;
      r_sb      <= '0;
      r_ex_op   <= '0;
      r_ex_rd   <= '0;
      r_ex_we   <= 1'b0;
      r_ex_long <= 1'b0;
      r_ex_mem  <= 1'b0;
      r_ex_br   <= 1'b0;
      r_ex_stop <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_we   <= 1'b0;
      r_wb_clr  <= 1'b0;
      r_wb_stop <= 1'b0;
      r_cnt     <= '0;
      r_mcnt    <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_sb <= (r_sb & ~w_clr) | w_set;

      if (w_kill)     r_v_id <= 1'b0;
      else if (if_en) r_v_id <= 1'b1;
      else if (w_adv) r_v_id <= 1'b0;

      if (w_adv) begin
        r_v_ex    <= 1'b1;
        r_ex_op   <= id_op;
        r_ex_rd   <= id_rd;
        r_ex_we   <= id_rd_we;
        r_ex_long <= id_is_long;
        r_ex_mem  <= id_is_mem;
        r_ex_br   <= id_is_branch;
        r_ex_stop <= id_is_stop;
      end else if (w_ex_done) begin
        r_v_ex  <= 1'b0;
        r_ex_op <= '0;
      end

      r_cnt <= (r_v_ex & r_ex_long & ~w_ex_done) ?
        r_cnt + 4'd1 : 4'd0;
      r_mcnt <= (r_v_ex & r_ex_mem & ~w_ex_done) ?
        r_mcnt + 8'd1 : 8'd0;

      r_v_wb <= w_ex_done;
      if (w_ex_done) begin
        r_wb_rd   <= r_ex_rd;
        r_wb_we   <= r_ex_we & ~w_to;
        r_wb_clr  <= r_ex_we;
        r_wb_stop <= r_ex_stop;
      end

      r_mem_err <= r_mem_err | w_to;

      unique case (r_state)
        S_IDLE:
          if (start_pr) r_state <= S_RUN;
        S_RUN:
          if (w_to) r_state <= S_DONE;
          else if (w_adv & id_is_stop)
            r_state <= S_DRAIN;
        S_DRAIN:
          if (w_to | (r_v_wb & r_wb_stop))
            r_state <= S_DONE;
        S_DONE:
          if (!start_pr) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: the bench acts as instruction
// memory, driving ID fields whenever the DUT fetches.
module tb_pipe_ctrl_unit;
  logic clk_in = 1'b0;
  logic rst_n = 1'b0;
  logic start_pr = 1'b0;
  logic end_pr, if_en, pc_load, id_adv, ex_valid;
  logic mem_req, wb_en, mem_err;
  logic [3:0] id_op, id_rd, id_rs1, id_rs2;
  logic [3:0] ex_op, wb_sel;
  logic id_rd_we, id_rs1_use, id_rs2_use;
  logic id_is_long, id_is_mem, id_is_branch, id_is_stop;
  logic ex_branch_taken, mem_ack;

  always #5 clk_in = ~clk_in;

  pipe_ctrl_unit #(
    .REGW(4), .OPW(4), .LONG_CYC(2), .MEM_TO(15)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n),
    .start_pr(start_pr), .end_pr(end_pr),
    .if_en(if_en), .pc_load(pc_load),
    .id_op(id_op), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd_we(id_rd_we),
    .id_rs1_use(id_rs1_use),
    .id_rs2_use(id_rs2_use),
    .id_is_long(id_is_long),
    .id_is_mem(id_is_mem),
    .id_is_branch(id_is_branch),
    .id_is_stop(id_is_stop),
    .id_adv(id_adv), .ex_valid(ex_valid),
    .ex_op(ex_op),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .wb_en(wb_en), .wb_sel(wb_sel),
    .mem_err(mem_err)
  );

  typedef struct packed {
    logic [3:0] op, rd, rs1, rs2;
    logic we, u1, u2, lg, mem, br, stp;
  } ins_t;

  ins_t prog [0:15];
  int total = 0;
  int bad = 0;
  int cyc_n, pc, br_tgt, ack_after;
  int req_run, req_tot, pcl_n, pcl_cyc;
  int exv_n, end_cyc, op3;
  logic s_if, s_pcl;
  int wb_c[$];
  int wb_s[$];
  int adv_c[$];

  function automatic ins_t mk(
    input int op, input int rd,
    input int rs1, input int rs2,
    input logic [6:0] fl);
    ins_t x;
    x.op  = 4'(op);
    x.rd  = 4'(rd);
    x.rs1 = 4'(rs1);
    x.rs2 = 4'(rs2);
    {x.we, x.u1, x.u2, x.lg, x.mem, x.br, x.stp} = fl;
    return x;
  endfunction

  task automatic chk(input string tag,
                     input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic load_ir(input ins_t x);
    id_op = x.op; id_rd = x.rd;
    id_rs1 = x.rs1; id_rs2 = x.rs2;
    id_rd_we = x.we; id_rs1_use = x.u1;
    id_rs2_use = x.u2; id_is_long = x.lg;
    id_is_mem = x.mem; id_is_branch = x.br;
    id_is_stop = x.stp;
  endtask

  task automatic clr_prog();
    for (int i = 0; i < 16; i++) prog[i] = '0;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    mem_ack = 1'b0;
    if (s_if) begin
      if (pc < 16) load_ir(prog[pc]);
      pc++;
    end else if (s_pcl) begin
      pc = br_tgt;
    end
    cyc_n++;
    @(negedge clk_in);
    s_if = if_en;
    s_pcl = pc_load;
    if (pc_load) begin pcl_n++; pcl_cyc = cyc_n; end
    if (id_adv) adv_c.push_back(cyc_n);
    if (wb_en) begin
      wb_c.push_back(cyc_n);
      wb_s.push_back(int'(wb_sel));
    end
    if (ex_valid) exv_n++;
    if (cyc_n == 3) op3 = int'(ex_op);
    if (mem_req) begin req_run++; req_tot++; end
    if (end_pr && end_cyc < 0) end_cyc = cyc_n;
    mem_ack = mem_req && ack_after >= 0 &&
              req_run == ack_after + 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start_pr = 1'b0;
    mem_ack = 1'b0;
    ex_branch_taken = 1'b0;
    load_ir('0);
    s_if = 1'b0;
    s_pcl = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic start_run();
    pc = 0; cyc_n = 0;
    req_run = 0; req_tot = 0;
    pcl_n = 0; pcl_cyc = -1;
    exv_n = 0; end_cyc = -1; op3 = -1;
    wb_c.delete(); wb_s.delete(); adv_c.delete();
    s_if = 1'b0; s_pcl = 1'b0;
    start_pr = 1'b1;
  endtask

  task automatic run(input int maxc);
    while (end_cyc < 0 && cyc_n < maxc) step();
    chk("end_seen", int'(end_cyc >= 0), 1);
  endtask

  task automatic leave_done();
    start_pr = 1'b0;
    step();
  endtask

  initial begin
    br_tgt = 4;
    ack_after = -1;
    clr_prog();
    do_reset();
    chk("rst_end_pr", int'(end_pr), 0);
    chk("rst_if_en", int'(if_en), 0);
    chk("rst_pc_load", int'(pc_load), 0);
    chk("rst_id_adv", int'(id_adv), 0);
    chk("rst_ex_valid", int'(ex_valid), 0);
    chk("rst_ex_op", int'(ex_op), 0);
    chk("rst_mem_req", int'(mem_req), 0);
    chk("rst_wb_en", int'(wb_en), 0);
    chk("rst_wb_sel", int'(wb_sel), 0);
    chk("rst_mem_err", int'(mem_err), 0);
    rst_n = 1'b1;

    // four independent ADDs then STOP
    for (int i = 0; i < 4; i++)
      prog[i] = mk(i + 1, i + 1, 0, 0, 7'b1000000);
    prog[4] = mk(15, 0, 0, 0, 7'b0000001);
    start_run();
    run(40);
    chk("add_wb_cnt", wb_c.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("add_wb_cyc", wb_c[i], 4 + i);
      chk("add_wb_sel", wb_s[i], i + 1);
    end
    chk("add_ex_op", op3, 1);
    chk("add_end_cyc", end_cyc, 9);
    step();
    chk("done_hold", int'(end_pr), 1);
    leave_done();
    chk("idle_end_pr", int'(end_pr), 0);
    chk("idle_if_en", int'(if_en), 0);

    // RAW: SUB r2 <- r1 right after ADD r1
    clr_prog();
    prog[0] = mk(1, 1, 0, 0, 7'b1000000);
    prog[1] = mk(2, 2, 1, 0, 7'b1100000);
    prog[2] = mk(15, 0, 0, 0, 7'b0000001);
    start_run();
    step();
    start_pr = 1'b0;
    run(40);
    chk("raw_adv0", adv_c[0], 2);
    chk("raw_adv1", adv_c[1], 5);
    chk("raw_wb0", wb_c[0], 4);
    chk("raw_wb1", wb_c[1], 7);
    chk("raw_sel1", wb_s[1], 2);
    step();
    // reading r1/r2 must not stall if the scoreboard drained
    clr_prog();
    prog[0] = mk(3, 5, 1, 2, 7'b1110000);
    prog[1] = mk(15, 0, 0, 0, 7'b0000001);
    start_run();
    run(40);
    chk("sb_clr_adv", adv_c[0], 2);
    chk("sb_clr_wb", wb_c[0], 4);
    leave_done();

    // long op, then independent ADD
    clr_prog();
    prog[0] = mk(4, 1, 0, 0, 7'b1001000);
    prog[1] = mk(1, 2, 0, 0, 7'b1000000);
    prog[2] = mk(15, 0, 0, 0, 7'b0000001);
    start_run();
    run(40);
    chk("long_wb0", wb_c[0], 6);
    chk("long_wb1", wb_c[1], 7);
    chk("long_exv", exv_n, 5);
    leave_done();

    // memory op acked on its fourth request cycle
    clr_prog();
    prog[0] = mk(5, 1, 0, 0, 7'b1000100);
    prog[1] = mk(15, 0, 0, 0, 7'b0000001);
    ack_after = 3;
    start_run();
    run(40);
    chk("mem_req_cyc", req_tot, 4);
    chk("mem_wb_cyc", wb_c[0], 7);
    chk("mem_wb_sel", wb_s[0], 1);
    chk("mem_no_err", int'(mem_err), 0);
    leave_done();

    // memory op never acked
    ack_after = -1;
    start_run();
    run(80);
    chk("to_req_cyc", req_tot, 15);
    chk("to_end_cyc", end_cyc, 19);
    chk("to_mem_err", int'(mem_err), 1);
    chk("to_no_wb", wb_c.size(), 0);

    do_reset();
    rst_n = 1'b1;
    chk("rst_err_clr", int'(mem_err), 0);

    // taken branch squashes ADD r7, target reads r7
    clr_prog();
    prog[0] = mk(6, 0, 0, 0, 7'b0000010);
    prog[1] = mk(1, 7, 0, 0, 7'b1000000);
    prog[2] = mk(15, 0, 0, 0, 7'b0000001);
    prog[4] = mk(1, 8, 7, 0, 7'b1100000);
    prog[5] = mk(15, 0, 0, 0, 7'b0000001);
    ex_branch_taken = 1'b1;
    start_run();
    run(40);
    chk("bt_pcl_n", pcl_n, 1);
    chk("bt_pcl_cyc", pcl_cyc, 3);
    chk("bt_wb_cnt", wb_c.size(), 1);
    chk("bt_wb_cyc", wb_c[0], 7);
    chk("bt_wb_sel", wb_s[0], 8);
    leave_done();

    // same program, branch not taken
    ex_branch_taken = 1'b0;
    start_run();
    run(40);
    chk("bn_pcl_n", pcl_n, 0);
    chk("bn_wb_cnt", wb_c.size(), 1);
    chk("bn_wb_cyc", wb_c[0], 5);
    chk("bn_wb_sel", wb_s[0], 7);
    leave_done();

    // reset in the middle of a memory access
    clr_prog();
    prog[0] = mk(5, 1, 0, 0, 7'b1000100);
    ack_after = -1;
    start_run();
    repeat (5) step();
    chk("mid_req_on", int'(mem_req), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_req_off", int'(mem_req), 0);
    chk("mid_exv_off", int'(ex_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Parametrised control unit for the four-stage in-order pipeline: IF, ID, EX, WB. It is the single-clock successor of the current two-phase pipeline state machine. It adds:
- a register scoreboard for RAW hazard stalls,
- a configurable multi-cycle (long) op latency,
- a req/ack memory handshake with timeout,
- an explicit run/stop state machine.

Opcode decoding is external; this block consumes decoded class flags and drives stage enables, write-back selects and memory strobes.

## Interface
Parameters:
- REGW, 4: register index width; scoreboard has 2**REGW entries.
- OPW, 4: opcode width, carried through to `ex_op`.
- LONG_CYC, 2: extra EX cycles for long ops (ADDI/SUBI/MUL/DIV class); range 1..15.
- MEM_TO, 15: memory ack timeout in cycles; range 1..255.

Ports:
- `clk_in`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_pr`  in  1  level; run request.
- `end_pr`  out  1  program stopped (STOP retired or memory error).
- `if_en`  out  1  PC increment plus IR load this cycle.
- `pc_load`  out  1  load PC with branch target this cycle.
- `id_op`  in  OPW  opcode in ID.
- `id_rd`, `id_rs1`, `id_rs2`  in  REGW each  register indices in ID.
- `id_rd_we`, `id_rs1_use`, `id_rs2_use`  in  1 each  operand/destination valid flags.
- `id_is_long`, `id_is_mem`, `id_is_branch`, `id_is_stop`  in  1 each  class flags.
- `id_adv`  out  1  latch ID operands into EX registers (A/B).
- `ex_valid`  out  1  EX holds a live instruction.
- `ex_op`  out  OPW  opcode to ALU; 0 (NOP) when `ex_valid`=0.
- `ex_branch_taken`  in  1  condition result (Z/N evaluated in datapath); sampled only on EX completion of a branch.
- `mem_req`  out  1  memory access request.
- `mem_ack`  in  1  memory completion.
- `wb_en`  out  1  register file write strobe.
- `wb_sel`  out  REGW  destination register for `wb_en`.
- `mem_err`  out  1  sticky; memory timeout occurred.

## Operation
Top FSM states are IDLE, RUN, DRAIN and DONE.
- IDLE → RUN when `start_pr`=1.
- RUN → DRAIN when an instruction with `id_is_stop` advances out of ID. Fetch stops from that cycle.
- DRAIN → DONE when the STOP reaches WB, or immediately on memory timeout.
- DONE → IDLE when `start_pr`=0. `end_pr`=1 only in DONE.

Stage valid bits are `v_id`, `v_ex` and `v_wb`. Instruction fields are latched into EX and WB registers on advance.
- `if_en`=1 iff state=RUN and ID is free or advancing, and no branch redirect this cycle. `v_id` is set the next cycle.
- Hazard: `v_id` and ((`id_rs1_use` and sb[`id_rs1`]) or (`id_rs2_use` and sb[`id_rs2`])). There is no bypass. A scoreboard bit cleared this cycle still stalls this cycle.
- `id_adv` = `v_id` and not hazard and (not `v_ex` or ex_done). On `id_adv` with `id_rd_we`, set sb[`id_rd`].
- ex_done:
  - plain op: first EX cycle.
  - long op: after LONG_CYC+1 cycles, using a 4-bit counter.
  - mem op: the cycle `mem_ack`=1, or timeout.
- `mem_req` = `v_ex` and ex_is_mem and not done. `mem_req` is asserted from the first EX cycle. `mem_ack` in the same cycle is legal.
- Memory timeout: an 8-bit counter reaches MEM_TO with no ack. Then:
  - `mem_err` is set,
  - the instruction completes with write disabled,
  - its scoreboard bit is cleared,
  - the FSM goes to DONE.
- Branch: on ex_done of a branch with `ex_branch_taken`=1:
  - `pc_load`=1,
  - `v_id` is cleared, its scoreboard set is suppressed, and `if_en`=0 that cycle.
  - A flush overrides a simultaneous `id_adv`.
  - A not-taken branch has no effect.
- WB, one cycle:
  - `wb_en` = `v_wb` and wb_rd_we.
  - `wb_sel` = wb_rd.
  - sb[wb_rd] is cleared at the clock edge ending the WB cycle.
- Scoreboard set and clear on the same index in the same cycle: set wins.

## Timing
- Reset (async): all outputs are 0, `ex_op`=0, state=IDLE, valid bits, scoreboard and counters are 0, and `mem_err` is 0.
- Reset mid-access drops `mem_req` immediately.
- Plain op latency: IF→WB is 4 cycles, throughput 1 per cycle.
- A long op stalls ID for LONG_CYC cycles.
- Branch-taken penalty: 2 cycles (the ID instruction is squashed, plus the redirect cycle).
- RAW back-to-back: dependent instruction waits in ID until the cycle after the producer's WB, i.e. 2 bubbles.
- `start_pr` deasserted in RUN has no effect; the program runs to STOP.

## Test plan
- Reset, `start_pr`=1, 4 independent ADDs (rd=1..4) → `wb_en` on cycles 4,5,6,7 with `wb_sel`=1,2,3,4; no stalls.
- ADD r1 then SUB r2←r1 → `id_adv` low 2 cycles; SUB `wb_en` 3 cycles after ADD's WB; sb all zero at the end.
- Long op with LONG_CYC=2 followed by an independent ADD → `ex_valid` for 3 cycles; ADD WB 2 cycles later than the pipelined case.
- Mem op, `mem_ack` after 3 cycles → `mem_req` high exactly 4 cycles. With ack never given and MEM_TO=15 → `mem_err`=1, `end_pr`=1.
- Taken branch → `pc_load` pulse; the following ID instruction produces no `wb_en` and sets no scoreboard bit. Not-taken branch → no `pc_load`.
- STOP retires → `end_pr`=1; drop `start_pr` → IDLE. Assert `rst_n`=0 mid-mem-access → `mem_req`=0 immediately.
